// File: rtl/panel_control.sv
`timescale 1ns/1ps
// panel_control: washer front panel. Debounces the five panel buttons and
// keeps power, run state, wash model, water level and reservation delay for
// the time controller; turns the controller's finish flag into a timed beep.
module panel_control #(
  parameter int N        = 100_000_000, // clk cycles per 1 s tick
  parameter int DEB      = 2_000_000,   // cycles a button level must be stable
  parameter int RES_STEP = 10,          // rest_time added per reserve press
  parameter int RES_MAX  = 99,          // largest rest_time; beyond it wraps to 0
  parameter int BEEP_S   = 3            // buzzer duration in ticks
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_power,
  input  logic       btn_start,
  input  logic       btn_model,
  input  logic       btn_water,
  input  logic       btn_reserve,
  input  logic       finish,
  output logic       power_light,
  output logic [1:0] run_state,
  output logic [2:0] current_model,
  output logic [2:0] current_water,
  output logic [6:0] rest_time,
  output logic       beep
);

  localparam int NB = 5;
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(N - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_S - 1);

  // Button positions inside the packed button vectors.
  localparam int B_POWER   = 0;
  localparam int B_START   = 1;
  localparam int B_MODEL   = 2;
  localparam int B_WATER   = 3;
  localparam int B_RESERVE = 4;

  localparam logic [2:0] MODEL_RST = 3'd0;
  localparam logic [2:0] MODEL_MAX = 3'd5;
  localparam logic [2:0] WATER_RST = 3'd2;
  localparam logic [2:0] WATER_MIN = 3'd1;
  localparam logic [2:0] WATER_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, stability counter, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic [NB-1:0]         btn_raw;
  logic [NB-1:0]         sync1_q, sync1_d;
  logic [NB-1:0]         sync2_q, sync2_d;
  logic [NB-1:0]         deb_q, deb_d;
  logic [NB-1:0]         press_q, press_d;
  logic [NB-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  assign btn_raw = {btn_reserve, btn_water, btn_model, btn_start, btn_power};

  // Accept a new level only after it has differed from the debounced one for DEB cycles.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
    // Only an accepted rising level is a press; releases produce nothing.
    press_d = deb_d & ~deb_q;
  end

  // Button path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Panel state machine, tick counter, reservation and beep timing
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            pwr_q, pwr_d;
  logic [2:0]      model_q, model_d;
  logic [2:0]      water_q, water_d;
  logic [6:0]      rest_q, rest_d;
  logic            beep_q, beep_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   beep_cnt_q, beep_cnt_d;

  logic            press_power, press_start, press_model, press_water, press_reserve;
  logic            counting;
  logic            tick;
  logic [7:0]      res_sum;

  assign press_power   = press_q[B_POWER];
  assign press_start   = press_q[B_START];
  assign press_model   = press_q[B_MODEL];
  assign press_water   = press_q[B_WATER];
  assign press_reserve = press_q[B_RESERVE];

  // The second counter runs while a reservation is being counted down and while beeping.
  assign counting = pwr_q && (((state_q == ST_RUN) && (rest_q != '0)) || (state_q == ST_DONE));
  assign tick     = counting && (tick_cnt_q == TICK_LAST);
  assign res_sum  = 8'(rest_q) + 8'(RES_STEP);

  // Next-state logic for power, run state and all panel settings.
  always_comb begin
    pwr_d      = pwr_q;
    state_d    = state_q;
    model_d    = model_q;
    water_d    = water_q;
    rest_d     = rest_q;
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;

    // Tick counter: run while counting, freeze in PAUSE, clear otherwise.
    if (counting) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end else if (state_q == ST_PAUSE) begin
      tick_cnt_d = tick_cnt_q;
    end else begin
      tick_cnt_d = '0;
    end

    if (press_power) begin
      // Power toggles and every other output falls back to its reset value;
      // this overrides any other event in the same cycle.
      pwr_d      = ~pwr_q;
      state_d    = ST_IDLE;
      model_d    = MODEL_RST;
      water_d    = WATER_RST;
      rest_d     = '0;
      beep_d     = 1'b0;
      beep_cnt_d = '0;
      tick_cnt_d = '0;
    end else if (pwr_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_model) begin
            model_d = (model_q == MODEL_MAX) ? MODEL_RST : model_q + 3'd1;
          end
          if (press_water) begin
            water_d = (water_q == WATER_MAX) ? WATER_MIN : water_q + 3'd1;
          end
          if (press_reserve) begin
            rest_d = (res_sum > 8'(RES_MAX)) ? '0 : res_sum[6:0];
          end
          if (press_start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A tick only fires here while rest_q is non-zero, so this never underflows.
          if (tick) begin
            rest_d = rest_q - 7'd1;
          end
          if (finish) begin
            state_d    = ST_DONE;
            beep_d     = 1'b1;
            beep_cnt_d = '0;
            tick_cnt_d = '0;
          end else if (press_start) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (press_start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (tick) begin
            if (beep_cnt_q == BEEP_LAST) begin
              state_d    = ST_IDLE;
              beep_d     = 1'b0;
              rest_d     = '0;
              beep_cnt_d = '0;
            end else begin
              beep_cnt_d = beep_cnt_q + BW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Panel state registers; every output comes straight from one of these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q      <= 1'b0;
      state_q    <= ST_IDLE;
      model_q    <= MODEL_RST;
      water_q    <= WATER_RST;
      rest_q     <= '0;
      beep_q     <= 1'b0;
      tick_cnt_q <= '0;
      beep_cnt_q <= '0;
    end else begin
      pwr_q      <= pwr_d;
      state_q    <= state_d;
      model_q    <= model_d;
      water_q    <= water_d;
      rest_q     <= rest_d;
      beep_q     <= beep_d;
      tick_cnt_q <= tick_cnt_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign power_light   = pwr_q;
  assign run_state     = state_q;
  assign current_model = model_q;
  assign current_water = water_q;
  assign rest_time     = rest_q;
  assign beep          = beep_q;

endmodule

// File: tb/tb_panel_control.sv
`timescale 1ns/1ps
// tb_panel_control: randomized button/finish stimulus against an elapsed-time
// reference model; expected outputs are queued per clock and popped by a
// separate monitor on the falling edge.
module tb_panel_control;

  localparam int N        = 5;
  localparam int DEB      = 3;
  localparam int RES_STEP = 10;
  localparam int RES_MAX  = 99;
  localparam int BEEP_S   = 3;

  // Press reaches the panel logic on the (2 + DEB + 1)-th edge after the raw rise.
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;   // 0 power, 1 start, 2 model, 3 water, 4 reserve
  logic       finish = 1'b0;

  logic       power_light;
  logic [1:0] run_state;
  logic [2:0] current_model;
  logic [2:0] current_water;
  logic [6:0] rest_time;
  logic       beep;

  panel_control #(
    .N(N), .DEB(DEB), .RES_STEP(RES_STEP), .RES_MAX(RES_MAX), .BEEP_S(BEEP_S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_power    (btn[0]),
    .btn_start    (btn[1]),
    .btn_model    (btn[2]),
    .btn_water    (btn[3]),
    .btn_reserve  (btn[4]),
    .finish       (finish),
    .power_light  (power_light),
    .run_state    (run_state),
    .current_model(current_model),
    .current_water(current_water),
    .rest_time    (rest_time),
    .beep         (beep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pwr;
    logic [1:0] st;
    logic [2:0] md;
    logic [2:0] wt;
    logic [6:0] rest;
    logic       beep;
  } snap_t;

  snap_t exp_q[$];
  snap_t act_s;
  int    total = 0;
  int    bad   = 0;

  assign act_s = {power_light, run_state, current_model, current_water, rest_time, beep};

  // ---------------------------------------------------------------------------
  // Reference model: remaining delay derived from cycles spent counting.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  bit m_pwr;
  int m_st, m_md, m_wt;
  int m_rest_start;   // rest_time when the current countdown began
  int m_run_el;       // RUN cycles spent with a reservation still pending
  int m_done_el;      // cycles spent in DONE
  bit m_beep;

  function automatic int rest_now();
    if (m_rest_start * N > m_run_el) return m_rest_start - m_run_el / N;
    return 0;
  endfunction

  task automatic model_reset();
    m_pwr = 0; m_st = M_IDLE; m_md = 0; m_wt = 2;
    m_rest_start = 0; m_run_el = 0; m_done_el = 0; m_beep = 0;
  endtask

  function automatic snap_t exp_snap();
    snap_t s;
    s.pwr  = m_pwr;
    s.st   = 2'(m_st);
    s.md   = 3'(m_md);
    s.wt   = 3'(m_wt);
    s.rest = 7'(rest_now());
    s.beep = m_beep;
    return s;
  endfunction

  // One clock edge of panel behaviour given the presses that land on it.
  task automatic model_edge(input logic [4:0] ev, input logic fin);
    int r;
    if (ev[0]) begin
      if (m_pwr) model_reset();
      else m_pwr = 1;
      return;
    end
    if (!m_pwr) return;
    case (m_st)
      M_IDLE: begin
        if (ev[2]) m_md = (m_md == 5) ? 0 : m_md + 1;
        if (ev[3]) m_wt = (m_wt == 5) ? 1 : m_wt + 1;
        if (ev[4]) begin
          r = rest_now() + RES_STEP;
          m_rest_start = (r > RES_MAX) ? 0 : r;
          m_run_el = 0;
        end
        if (ev[1]) begin
          m_rest_start = rest_now();
          m_run_el = 0;
          m_st = M_RUN;
        end
      end
      M_RUN: begin
        if (rest_now() > 0) m_run_el++;
        if (fin) begin
          m_st = M_DONE; m_beep = 1; m_done_el = 0;
        end else if (ev[1]) begin
          m_st = M_PAUSE;
        end
      end
      M_PAUSE: if (ev[1]) m_st = M_RUN;
      default: begin
        m_done_el++;
        if (m_done_el == BEEP_S * N) begin
          m_st = M_IDLE; m_beep = 0; m_rest_start = 0; m_run_el = 0;
        end
      end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input snap_t act, input snap_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got pwr=%0d st=%0d model=%0d water=%0d rest=%0d beep=%0d want pwr=%0d st=%0d model=%0d water=%0d rest=%0d beep=%0d",
               name, $time, act.pwr, act.st, act.md, act.wt, act.rest, act.beep,
               exp.pwr, exp.st, exp.md, exp.wt, exp.rest, exp.beep);
    end
  endtask

  // Monitor: compare the DUT outputs against the queued expectation mid-cycle.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", act_s, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic edge_ev(input logic [4:0] ev);
    @(posedge clk);
    model_edge(ev, finish);
    exp_q.push_back(exp_snap());
    #1;
  endtask

  task automatic idle(input int k, input bit rand_fin);
    for (int i = 0; i < k; i++) begin
      finish = rand_fin && ($urandom_range(0, 11) == 0);
      edge_ev('0);
      finish = 1'b0;
    end
  endtask

  // Press button b, optionally with a short glitch before it and a bouncy release.
  task automatic press(input int b, input bit bounce, input bit fin_at_press);
    logic [4:0] ev;
    ev = '0;
    ev[b] = 1'b1;
    if (bounce) begin
      btn[b] = 1'b1;
      idle(2, 0);
      btn[b] = 1'b0;
      idle(3, 0);
    end
    btn[b] = 1'b1;
    idle(PRESS_LAT - 1, 0);
    finish = fin_at_press;
    edge_ev(ev);
    finish = 1'b0;
    idle($urandom_range(0, 3), 0);
    btn[b] = 1'b0;
    if (bounce) begin
      idle(2, 0);
      btn[b] = 1'b1;
      idle(2, 0);
      btn[b] = 1'b0;
    end
    idle(DEB + 4, 0);
  endtask

  // Watchdog: the run is cycle-bounded, so this only fires if the bench stalls.
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at t=%0t total=%0d", $time, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    bit bn;
    model_reset();

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(exp_snap());
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Presses and finish while powered off change nothing.
    press(1, 0, 0);
    press(2, 0, 0);
    press(3, 0, 0);
    press(4, 0, 0);
    idle(10, 1);

    // Bouncy power press: exactly one toggle.
    press(0, 1, 0);

    // Model wraps 5 -> 0, water wraps 5 -> 1.
    for (int i = 0; i < 7; i++) press(2, $urandom_range(0, 1), 0);
    for (int i = 0; i < 4; i++) press(3, $urandom_range(0, 1), 0);

    // Settings are locked outside IDLE; pause/resume; finish beats start.
    press(1, 0, 0);
    press(2, 0, 0);
    press(4, 0, 0);
    press(1, 0, 0);
    idle(4, 1);
    press(1, 0, 0);
    idle(5, 0);
    press(1, 0, 1);
    idle(20, 0);

    // Reservation wraps after ten presses, then a 10-tick countdown with a pause.
    for (int i = 0; i < 10; i++) press(4, 0, 0);
    press(4, 0, 0);
    press(1, 0, 0);
    idle(12, 0);
    press(1, 0, 0);
    idle(9, 0);
    press(1, 0, 0);
    idle(40, 0);
    press(1, 0, 1);
    idle(20, 0);

    // Power press on the same cycle as finish: power wins, no beep.
    press(1, 0, 0);
    idle(3, 0);
    press(0, 0, 1);
    idle(5, 1);
    press(0, 0, 0);

    // Randomized operation mix.
    for (int k = 0; k < 220; k++) begin
      op = $urandom_range(0, 19);
      bn = 1'($urandom_range(0, 1));
      if (op == 0)       press(0, bn, 0);
      else if (op <= 4)  press(1, bn, 0);
      else if (op <= 6)  press(2, bn, 0);
      else if (op <= 8)  press(3, bn, 0);
      else if (op <= 11) press(4, bn, 0);
      else if (op == 12) press(1, bn, 1);
      else               idle($urandom_range(1, 40), 1);
      if (!m_pwr && ($urandom_range(0, 3) != 0)) press(0, 0, 0);
    end

    // Let the monitor drain the last expectation.
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panel_control.md
Name: panel_control

Overview:
- Front-panel controller for the washer. Debounces the five panel buttons and maintains power, run state, wash model, water level and reservation delay.
- Drives the time controller's inputs: power_light, run_state, current_model, current_water, rest_time.
- Consumes the controller's finish flag to end a cycle, sound the buzzer and return to idle.

Parameters:
- N, 100_000_000, clk cycles per 1 s tick (5 for simulation).
- DEB, 2_000_000, cycles a synchronized button level must stay stable to be accepted (3 for simulation).
- RES_STEP, 10, rest_time increment per reserve press.
- RES_MAX, 99, largest rest_time value; the next press wraps to 0.
- BEEP_S, 3, buzzer duration in ticks after finish.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_power  in  1  raw power button, active high.
- btn_start  in  1  raw start/pause button.
- btn_model  in  1  raw model-select button.
- btn_water  in  1  raw water-level button.
- btn_reserve  in  1  raw reservation button.
- finish  in  1  program-complete flag from the time controller.
- power_light  out  1  power on indicator / controller enable.
- run_state  out  2  00 idle, 01 run, 10 pause, 11 done.
- current_model  out  3  0..5: wash-rinse-spin, wash, wash-rinse, rinse, rinse-spin, spin.
- current_water  out  3  water level 1..5.
- rest_time  out  7  remaining reservation delay in ticks.
- beep  out  1  buzzer drive.

Behaviour:
- Reset (rst_n=0, asynchronous): power_light=0, run_state=00, current_model=0, current_water=2, rest_time=0, beep=0. Tick counter, beep counter and debouncers are cleared; debounced levels are set to 0.
- Button path:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level updates once the synchronized level has differed from it for DEB consecutive cycles.
  - A debounced rising edge gives a 1-cycle press pulse.
  - Press latency is 2+DEB+1 cycles from the raw edge.
  - Releases and bounces generate nothing.
- Power:
  - A power press toggles power_light.
  - Power off: all other outputs return to their reset values in the same cycle.
  - While power_light=0, all other presses and finish are ignored.
  - Power press has priority over every other event in the same cycle.
- Run state machine (power on):
  - IDLE: start press -> RUN.
  - IDLE: model press -> current_model+1, with 5 wrapping to 0.
  - IDLE: water press -> current_water+1, with 5 wrapping to 1.
  - IDLE: reserve press -> rest_time+RES_STEP; if the result exceeds RES_MAX, rest_time=0.
  - RUN: finish=1 -> DONE. finish beats a same-cycle start press.
  - RUN: otherwise start press -> PAUSE.
  - PAUSE: start press -> RUN. finish is ignored.
  - DONE: beep=1. Once BEEP_S ticks have elapsed, next state is IDLE with beep=0 and rest_time=0. All presses except power are ignored.
  - Model, water and reserve presses outside IDLE are ignored.
- Tick counter:
  - Counts 0..N-1 in RUN with rest_time>0, and in DONE.
  - Holds its value in PAUSE; cleared in every other case.
  - A tick fires on the cycle the counter equals N-1, and the counter wraps to 0.
- rest_time:
  - In RUN, each tick decrements it; it stops at 0 and never goes below.
  - Held in PAUSE.
  - While rest_time>0 the time controller does not advance.
  - Timing: with rest_time=1 at entry to RUN, it reaches 0 exactly N cycles later.
- Beep counter:
  - Cleared on entry to DONE and increments on each tick in DONE.
  - When it reaches BEEP_S, run_state goes to 00 and beep goes to 0 on the next edge.
- Entering IDLE, current_model and current_water are kept unchanged.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset, then release rst_n -> power_light=0, run_state=00, model=0, water=2, rest_time=0, beep=0. Presses other than power produce no change.
- Press power with DEB=3, including 2-cycle bounce glitches -> exactly one toggle, power_light=1 at the cycle 6 after the clean edge. Second press -> 0, outputs at defaults.
- Power on, model pressed 7 times -> current_model=1. Water pressed 4 times -> current_water=1. Start, then model press -> model unchanged.
- Reserve pressed 10 times -> rest_time=0 after the 10th. Press once more (10), then start with N=5 -> rest_time reaches 0 after 50 cycles. A pause inserted midway freezes both the count and the counter.
- RUN, assert finish for 1 cycle together with a start press -> run_state=11 next cycle, beep=1 for 15 cycles (BEEP_S=3, N=5), then run_state=00, beep=0.
- In RUN, power press on the same cycle as finish -> power_light=0, run_state=00, beep stays 0.
